// File: rtl/tt_sar_pkg.sv
// Shared constants for the SAR ADC controller: FSM state codes and default geometry.
package tt_sar_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 3;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single asynchronous input, async active-low reset.
module tt_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_sar_adc_ctrl.sv
// SAR ADC controller: binary-searches an R2R ladder code against an external
// comparator and publishes a WIDTH-bit result with a one-cycle done pulse.
module tt_sar_adc_ctrl
    import tt_sar_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic             track,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int BW    = $clog2(WIDTH);
    localparam int CMAX  = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]    TOP_BIT     = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (SETTLE_CYCLES < 3 || WIDTH < 2 || SAMPLE_CYCLES < 1) begin : g_bad_params
            $error("tt_sar_adc_ctrl: need WIDTH>=2, SAMPLE_CYCLES>=1, SETTLE_CYCLES>=3");
        end
    endgenerate

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BW-1:0]    bit_idx;
    logic             cmp_sync;
    logic [WIDTH-1:0] decided;
    logic [WIDTH-1:0] trial_next;

    tt_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    // Current trial bit is kept only if Vin >= Vdac; next lower bit becomes the new trial.
    always_comb begin
        decided = dac_code;
        if (!cmp_sync) decided[bit_idx] = 1'b0;
        trial_next = decided;
        trial_next[bit_idx - BW'(1)] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            dac_code <= '0;
            result   <= '0;
        end else if (!ena) begin
            // Abort drops any partial code; the ladder shows the last good result.
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            dac_code <= result;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    dac_code <= result;
                    if (start) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (cnt == SAMPLE_LAST) begin
                        cnt      <= '0;
                        bit_idx  <= TOP_BIT;
                        dac_code <= MSB_CODE;
                        state    <= ST_SETTLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (bit_idx != '0) begin
                        dac_code <= trial_next;
                        bit_idx  <= bit_idx - BW'(1);
                        state    <= ST_SETTLE;
                    end else begin
                        dac_code <= decided;
                        result   <= decided;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt   <= '0;
                    state <= cont ? ST_SAMPLE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign track = (state == ST_SAMPLE);
    assign done  = (state == ST_DONE);
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_tt_sar_adc_ctrl.sv
// Randomized self-checking bench for tt_sar_adc_ctrl against a behavioural binary-search model.
// Edge numbering: the edge that samples start is edge 1; done is expected visible after edge 37.
module tb_tt_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       cmp_in;
    logic       track, done, busy;
    logic [7:0] dac_code, result;
    logic [7:0] vin = 8'h00;
    logic       stuck = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // Comparator: 1 when Vin >= Vdac, or forced high to model a stuck comparator.
    assign cmp_in = stuck || (vin >= dac_code);

    tt_sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .cont     (cont),
        .cmp_in   (cmp_in),
        .track    (track),
        .dac_code (dac_code),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal SAR outcome: greedily keep each bit, MSB first, while the comparator says Vin >= trial.
    function automatic int model_conv(input int v, input bit stk);
        int c = 0;
        for (int b = 7; b >= 0; b--) begin
            if (stk || v >= (c | (1 << b))) c = c | (1 << b);
        end
        return c;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_conv(input int v, input bit repulse);
        int code, trial, ndone, done_at;
        code = 0; ndone = 0; done_at = 0;
        vin = 8'(v);
        pulse_start();
        chk("track_on", int'(track), 1);
        chk("busy_on", int'(busy), 1);
        for (int e = 2; e <= 42; e++) begin
            @(posedge clk);
            #1;
            if (e >= 5 && e <= 33 && (e - 5) % 4 == 0) begin
                trial = code | (8'h80 >> ((e - 5) / 4));
                chk("trial", int'(dac_code), trial);
                if (stuck || v >= trial) code = trial;
            end
            if (e == 4) chk("track_hold", int'(track), 1);
            if (e == 5) chk("track_off", int'(track), 0);
            if (done) begin ndone++; done_at = e; end
            if (e == 38) chk("busy_off", int'(busy), 0);
            start = repulse && (e == 4 || e == 19);
        end
        chk("ndone", ndone, 1);
        chk("done_at", done_at, 37);
        chk("result", int'(result), model_conv(v, stuck));
        chk("idle_dac", int'(dac_code), model_conv(v, stuck));
    endtask

    initial begin
        int ndone, d1, d2, busy_seen;
        bit prev_done;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_track", int'(track), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_result", int'(result), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        repeat (2) @(posedge clk);

        // Directed and boundary conversions
        do_conv(8'hA5, 1'b0);
        do_conv(8'hFF, 1'b0);
        do_conv(8'h00, 1'b0);
        do_conv(8'h01, 1'b0);
        do_conv(8'hA5, 1'b1);
        stuck = 1'b1;
        do_conv(8'h00, 1'b0);
        stuck = 1'b0;

        // Random conversions
        repeat (8) do_conv(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // Continuous mode, input changed between conversions
        cont = 1'b1;
        vin = 8'h3C;
        ndone = 0; d1 = 0; d2 = 0; prev_done = 1'b0;
        pulse_start();
        for (int e = 2; e <= 90; e++) begin
            @(posedge clk);
            #1;
            if (prev_done) chk("cont_track_re", int'(track), (ndone == 1) ? 1 : 0);
            prev_done = done;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = e;
                    chk("cont_res1", int'(result), model_conv(8'h3C, 1'b0));
                    vin = 8'hC3;
                end else if (ndone == 2) begin
                    d2 = e;
                    chk("cont_res2", int'(result), model_conv(8'hC3, 1'b0));
                    cont = 1'b0;
                end
            end
        end
        chk("cont_ndone", ndone, 2);
        chk("cont_first", d1, 37);
        chk("cont_gap", d2 - d1, 37);

        // Asynchronous reset mid-conversion
        vin = 8'h5A;
        pulse_start();
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", int'({track, done, busy, dac_code, result}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy || done || track) busy_seen++;
        end
        chk("midrst_idle", busy_seen, 0);
        do_conv(8'h5A, 1'b0);

        // ena low mid-conversion
        do_conv(8'h33, 1'b0);
        vin = 8'h77;
        pulse_start();
        repeat (14) @(posedge clk);
        #1 ena = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_track", int'(track), 0);
        chk("abort_dac", int'(dac_code), 8'h33);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        chk("abort_result", int'(result), 8'h33);
        ena = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
